mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage between EX and the WB segment register. Latches one EX-stage instruction,
//  performs its data-memory load/store over a valid/ready request + response bus, aligns and
//  sign/zero-extends load data, then presents the result to WB with a valid/ready handshake.
//  Holds at most one instruction; stalls EX while a bus access or WB back-pressure is pending.
// PARAMETERS
//  none (XLEN fixed at 32; bus is 32-bit word addressed with 4 byte strobes)
// PORTS
//  clock            in   1   rising-edge clock
//  reset            in   1   asynchronous, active-low (0 = reset)
//  ex_valid         in   1   EX presents a valid instruction
//  mem_ready        out  1   stage can accept from EX this cycle
//  mem_valid        out  1   *_mem outputs hold a completed instruction
//  wb_ready         in   1   WB accepts this cycle
//  pc_ex, inst_ex, alu_res_ex, csr_rdata_ex, csr_wdata_ex, store_data_ex   in 32 each
//  mem_ren_ex, mem_wen_ex   in 1   load / store
//  mem_funct3_ex    in   3   access size/sign (RV32I funct3)
//  sel_rf_wdata_ex  in   3   rf write-data select, passed through
//  rf_wen_ex, csr_wen_ex, ecall_en_ex, mret_en_ex, ebreak_ex   in 1 each, passed through
//  pc_mem, inst_mem, alu_res_mem, csr_rdata_mem, csr_wdata_mem   out 32 each, registered
//  load_data_mem    out  32  aligned, extended load result (0 for non-loads)
//  sel_rf_wdata_mem out  3;  rf_wen_mem, csr_wen_mem, ecall_en_mem, mret_en_mem, ebreak_mem  out 1
//  dmem_req_valid   out  1   request valid
//  dmem_req_ready   in   1   request accepted
//  dmem_addr        out  32  {alu_res[31:2],2'b00}
//  dmem_wen         out  1   1 = store
//  dmem_wdata       out  32  store data shifted to byte lane
//  dmem_wstrb       out  4   byte strobes (0 for loads)
//  dmem_resp_valid  in   1   response / write-ack valid
//  dmem_rdata       in   32  load word
// BEHAVIOUR
//  - FSM: IDLE, REQ, RESP, HOLD. mem_ready = IDLE | (HOLD & wb_ready). mem_valid = (state==HOLD).
//  - Accept (ex_valid & mem_ready): latch all *_ex fields; next = REQ if mem_ren|mem_wen, else HOLD.
//  - REQ: dmem_req_valid=1, addr/wen/wdata/wstrb stable until dmem_req_ready=1 -> RESP.
//  - RESP: dmem_req_valid=0; resp sampled only here (earliest 1 cycle after accept). On resp_valid:
//    load -> latch extended data; store -> ack only; -> HOLD. Loads and stores both wait.
//  - HOLD: outputs stable while wb_ready=0. wb_ready=1: with ex_valid, accept next (back-to-back,
//    no bubble); else -> IDLE. In IDLE, control outputs (rf_wen/csr_wen/ecall/mret/ebreak_mem) read 0.
//  - Offset o=alu_res[1:0]. Store: SB strb=1<<o, SH strb=3<<o, SW 4'b1111; wdata=store_data<<(8*o).
//  - Load: w=dmem_rdata>>(8*o); 000 LB sext w[7:0], 001 LH sext w[15:0], 010 LW w,
//    100 LBU zext w[7:0], 101 LHU zext w[15:0]; other funct3 -> w unmodified.
//  - resp_valid outside RESP is ignored; req_ready outside REQ is ignored.
//  - Reset (async): state=IDLE, mem_valid=0, dmem_req_valid=0, all *_mem outputs and
//    load_data_mem = 0. Reset mid-access abandons it; late response after release is dropped.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: adds output misalign_mem (1 bit, reset 0). LH/LHU/SH with o[0]=1
//  or LW/SW with o!=0: no bus request, go directly to HOLD, misalign_mem=1, rf_wen_mem=0,
//  load_data_mem=0. Undefined: port absent; misaligned accesses issue as computed, lanes past
//  byte 3 dropped.
// TESTING
//  1 LB alu_res=0x80000003, rdata=0x80FF1234 -> dmem_addr=0x80000000, wstrb=0,
//    load_data_mem=0xFFFFFF80, mem_valid 1 cycle after resp_valid.
//  2 SH alu_res=0x80000002, store_data=0x0000ABCD -> wstrb=4'b1100, wdata=0xABCD0000, wen=1;
//    HOLD only after resp_valid.
//  3 ALU op (no mem) accepted -> no dmem_req_valid, mem_valid=1 next cycle; wb_ready=0 for 3 cycles
//    -> mem_ready=0, *_mem stable; wb_ready=1 & ex_valid=1 -> next instr latched same edge.
//  4 req_ready held 0 for 4 cycles -> req_valid, addr, wdata, wstrb unchanged; EX stalled.
//  5 reset=0 in RESP -> all outputs reset immediately; resp_valid=1 after release ->
//    no mem_valid, state IDLE.
//  6 MEM_MISALIGN_TRAP_EN: LW alu_res=0x80000001 -> no request, misalign_mem=1, rf_wen_mem=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches one EX instruction, runs its load/store over a valid/ready
// data bus, aligns and extends load data, and hands the result to WB. Option: MEM_MISALIGN_TRAP_EN.
module mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        mem_ready,
    output logic        mem_valid,
    input  logic        wb_ready,
    input  logic [31:0] pc_ex,
    input  logic [31:0] inst_ex,
    input  logic [31:0] alu_res_ex,
    input  logic [31:0] csr_rdata_ex,
    input  logic [31:0] csr_wdata_ex,
    input  logic [31:0] store_data_ex,
    input  logic        mem_ren_ex,
    input  logic        mem_wen_ex,
    input  logic [2:0]  mem_funct3_ex,
    input  logic [2:0]  sel_rf_wdata_ex,
    input  logic        rf_wen_ex,
    input  logic        csr_wen_ex,
    input  logic        ecall_en_ex,
    input  logic        mret_en_ex,
    input  logic        ebreak_ex,
    output logic [31:0] pc_mem,
    output logic [31:0] inst_mem,
    output logic [31:0] alu_res_mem,
    output logic [31:0] csr_rdata_mem,
    output logic [31:0] csr_wdata_mem,
    output logic [31:0] load_data_mem,
    output logic [2:0]  sel_rf_wdata_mem,
    output logic        rf_wen_mem,
    output logic        csr_wen_mem,
    output logic        ecall_en_mem,
    output logic        mret_en_mem,
    output logic        ebreak_mem,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_mem,
`endif
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} state_t;

    state_t      state;
    logic        ren_q;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] store_data_q;
    logic        accept;
    logic        misaligned_ex;
    logic [1:0]  offset;

    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [31:0] rdata,
                                                input logic [1:0]  o);
        logic [31:0] w;
        w = rdata >> {o, 3'b000};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign mem_ready      = (state == S_IDLE) || ((state == S_HOLD) && wb_ready);
    assign mem_valid      = (state == S_HOLD);
    assign accept         = ex_valid && mem_ready;
    assign dmem_req_valid = (state == S_REQ);
    assign offset         = alu_res_mem[1:0];
    assign dmem_addr      = {alu_res_mem[31:2], 2'b00};
    assign dmem_wen       = wen_q;
    // Lanes shifted past byte 3 fall off the top of the word.
    assign dmem_wdata     = store_data_q << {offset, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned_ex = (mem_ren_ex || mem_wen_ex) &&
                           (((mem_funct3_ex[1:0] == 2'b01) && alu_res_ex[0]) ||
                            ((mem_funct3_ex[1:0] == 2'b10) && (alu_res_ex[1:0] != 2'b00)));
`else
    assign misaligned_ex = 1'b0;
`endif

    // NOTE: always_comb assigns a default first so no path leaves dmem_wstrb unassigned (no latch).
    always_comb begin
        dmem_wstrb = 4'b0000;
        if (wen_q) begin
            case (funct3_q[1:0])
                2'b00:   dmem_wstrb = 4'b0001 << offset;
                2'b01:   dmem_wstrb = 4'b0011 << offset;
                default: dmem_wstrb = 4'b1111;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            ren_q            <= 1'b0;
            wen_q            <= 1'b0;
            funct3_q         <= 3'd0;
            store_data_q     <= 32'd0;
            pc_mem           <= 32'd0;
            inst_mem         <= 32'd0;
            alu_res_mem      <= 32'd0;
            csr_rdata_mem    <= 32'd0;
            csr_wdata_mem    <= 32'd0;
            load_data_mem    <= 32'd0;
            sel_rf_wdata_mem <= 3'd0;
            rf_wen_mem       <= 1'b0;
            csr_wen_mem      <= 1'b0;
            ecall_en_mem     <= 1'b0;
            mret_en_mem      <= 1'b0;
            ebreak_mem       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_mem     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        ren_q            <= mem_ren_ex;
                        wen_q            <= mem_wen_ex;
                        funct3_q         <= mem_funct3_ex;
                        store_data_q     <= store_data_ex;
                        pc_mem           <= pc_ex;
                        inst_mem         <= inst_ex;
                        alu_res_mem      <= alu_res_ex;
                        csr_rdata_mem    <= csr_rdata_ex;
                        csr_wdata_mem    <= csr_wdata_ex;
                        load_data_mem    <= 32'd0;
                        sel_rf_wdata_mem <= sel_rf_wdata_ex;
                        rf_wen_mem       <= rf_wen_ex && !misaligned_ex;
                        csr_wen_mem      <= csr_wen_ex;
                        ecall_en_mem     <= ecall_en_ex;
                        mret_en_mem      <= mret_en_ex;
                        ebreak_mem       <= ebreak_ex;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_mem     <= misaligned_ex;
`endif
                        state <= ((mem_ren_ex || mem_wen_ex) && !misaligned_ex) ? S_REQ : S_HOLD;
                    end else if ((state == S_HOLD) && wb_ready) begin
                        // Control bits read 0 while idle so WB never sees a stale write enable.
                        rf_wen_mem   <= 1'b0;
                        csr_wen_mem  <= 1'b0;
                        ecall_en_mem <= 1'b0;
                        mret_en_mem  <= 1'b0;
                        ebreak_mem   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_mem <= 1'b0;
`endif
                        state        <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready) state <= S_RESP;
                end
                S_RESP: begin
                    if (dmem_resp_valid) begin
                        if (ren_q) load_data_mem <= extend_load(funct3_q, dmem_rdata, offset);
                        state <= S_HOLD;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: loads, stores, ALU pass-through, back-pressure,
// request stalls and reset mid-access, all with hand-computed expectations.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid, mem_ready, mem_valid, wb_ready;
    logic [31:0] pc_ex, inst_ex, alu_res_ex, csr_rdata_ex, csr_wdata_ex, store_data_ex;
    logic        mem_ren_ex, mem_wen_ex;
    logic [2:0]  mem_funct3_ex, sel_rf_wdata_ex;
    logic        rf_wen_ex, csr_wen_ex, ecall_en_ex, mret_en_ex, ebreak_ex;
    logic [31:0] pc_mem, inst_mem, alu_res_mem, csr_rdata_mem, csr_wdata_mem, load_data_mem;
    logic [2:0]  sel_rf_wdata_mem;
    logic        rf_wen_mem, csr_wen_mem, ecall_en_mem, mret_en_mem, ebreak_mem;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_mem;
`endif
    logic        dmem_req_valid, dmem_req_ready, dmem_wen, dmem_resp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_stage dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .mem_ready(mem_ready), .mem_valid(mem_valid), .wb_ready(wb_ready),
        .pc_ex(pc_ex), .inst_ex(inst_ex), .alu_res_ex(alu_res_ex),
        .csr_rdata_ex(csr_rdata_ex), .csr_wdata_ex(csr_wdata_ex), .store_data_ex(store_data_ex),
        .mem_ren_ex(mem_ren_ex), .mem_wen_ex(mem_wen_ex), .mem_funct3_ex(mem_funct3_ex),
        .sel_rf_wdata_ex(sel_rf_wdata_ex), .rf_wen_ex(rf_wen_ex), .csr_wen_ex(csr_wen_ex),
        .ecall_en_ex(ecall_en_ex), .mret_en_ex(mret_en_ex), .ebreak_ex(ebreak_ex),
        .pc_mem(pc_mem), .inst_mem(inst_mem), .alu_res_mem(alu_res_mem),
        .csr_rdata_mem(csr_rdata_mem), .csr_wdata_mem(csr_wdata_mem), .load_data_mem(load_data_mem),
        .sel_rf_wdata_mem(sel_rf_wdata_mem), .rf_wen_mem(rf_wen_mem), .csr_wen_mem(csr_wen_mem),
        .ecall_en_mem(ecall_en_mem), .mret_en_mem(mret_en_mem), .ebreak_mem(ebreak_mem),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_mem(misalign_mem),
`endif
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
        .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge; all driving and sampling happens there.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; mem_ren_ex = 0; mem_wen_ex = 0; mem_funct3_ex = 3'd0;
        pc_ex = 0; inst_ex = 0; alu_res_ex = 0; csr_rdata_ex = 0; csr_wdata_ex = 0;
        store_data_ex = 0; sel_rf_wdata_ex = 0; rf_wen_ex = 0; csr_wen_ex = 0;
        ecall_en_ex = 0; mret_en_ex = 0; ebreak_ex = 0;
    endtask

    // Full load from IDLE: accept, one-cycle grant, immediate response, one WB beat.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] rdata, input logic [31:0] exp);
        ex_valid = 1; mem_ren_ex = 1; mem_funct3_ex = f3; alu_res_ex = alu; rf_wen_ex = 1;
        wb_ready = 0;
        tick();
        clear_ex();
        check({tag, "_req"}, dmem_req_valid, 1);
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0; dmem_resp_valid = 1; dmem_rdata = rdata;
        tick();
        dmem_resp_valid = 0;
        check({tag, "_data"}, load_data_mem, exp);
        wb_ready = 1;
        tick();
        wb_ready = 0;
        check({tag, "_idle"}, mem_valid, 0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] data, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        ex_valid = 1; mem_wen_ex = 1; mem_funct3_ex = f3; alu_res_ex = alu; store_data_ex = data;
        wb_ready = 0;
        tick();
        clear_ex();
        check({tag, "_strb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0; dmem_resp_valid = 1;
        tick();
        dmem_resp_valid = 0;
        check({tag, "_hold"}, mem_valid, 1);
        wb_ready = 1;
        tick();
        wb_ready = 0;
    endtask

    initial begin
        reset = 0;
        clear_ex();
        wb_ready = 0; dmem_req_ready = 0; dmem_resp_valid = 0; dmem_rdata = 0;
        #2;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_req_valid", dmem_req_valid, 0);
        check("rst_pc_mem", pc_mem, 0);
        check("rst_load_data", load_data_mem, 0);
        check("rst_mem_ready", mem_ready, 1);
        tick();
        reset = 1;
        tick();

        // 1: LB at offset 3, byte 0x80 sign-extended.
        ex_valid = 1; mem_ren_ex = 1; mem_funct3_ex = 3'b000; alu_res_ex = 32'h8000_0003;
        pc_ex = 32'h100; rf_wen_ex = 1;
        check("t1_accept_ready", mem_ready, 1);
        tick();
        clear_ex();
        check("t1_req_valid", dmem_req_valid, 1);
        check("t1_addr", dmem_addr, 32'h8000_0000);
        check("t1_wstrb", {28'd0, dmem_wstrb}, 0);
        check("t1_wen", dmem_wen, 0);
        check("t1_stall", mem_ready, 0);
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        check("t1_resp_noreq", dmem_req_valid, 0);
        check("t1_resp_novalid", mem_valid, 0);
        dmem_resp_valid = 1; dmem_rdata = 32'h80FF_1234;
        tick();
        dmem_resp_valid = 0;
        check("t1_mem_valid", mem_valid, 1);
        check("t1_load_data", load_data_mem, 32'hFFFF_FF80);
        check("t1_pc_mem", pc_mem, 32'h100);
        check("t1_rf_wen", rf_wen_mem, 1);
        wb_ready = 1;
        tick();
        wb_ready = 0;
        check("t1_idle_valid", mem_valid, 0);
        check("t1_idle_rf_wen", rf_wen_mem, 0);

        // 2: SH at offset 2; no HOLD until the write ack arrives.
        ex_valid = 1; mem_wen_ex = 1; mem_funct3_ex = 3'b001; alu_res_ex = 32'h8000_0002;
        store_data_ex = 32'h0000_ABCD;
        tick();
        clear_ex();
        check("t2_wstrb", {28'd0, dmem_wstrb}, 32'hC);
        check("t2_wdata", dmem_wdata, 32'hABCD_0000);
        check("t2_wen", dmem_wen, 1);
        check("t2_addr", dmem_addr, 32'h8000_0000);
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        tick();
        check("t2_wait_ack", mem_valid, 0);
        dmem_resp_valid = 1;
        tick();
        dmem_resp_valid = 0;
        check("t2_hold", mem_valid, 1);
        check("t2_load_zero", load_data_mem, 0);
        wb_ready = 1;
        tick();
        wb_ready = 0;

        // 3: ALU op, WB back-pressure, then back-to-back accept.
        ex_valid = 1; pc_ex = 32'h200; inst_ex = 32'h0000_AAAA; alu_res_ex = 32'h1234; rf_wen_ex = 1;
        tick();
        check("t3_no_req", dmem_req_valid, 0);
        check("t3_valid", mem_valid, 1);
        pc_ex = 32'h204; alu_res_ex = 32'h5678; inst_ex = 32'h0000_BBBB;
        for (int i = 0; i < 3; i++) begin
            check("t3_bp_ready", mem_ready, 0);
            check("t3_bp_pc", pc_mem, 32'h200);
            check("t3_bp_alu", alu_res_mem, 32'h1234);
            tick();
        end
        check("t3_bp_inst", inst_mem, 32'h0000_AAAA);
        wb_ready = 1;
        #1;
        check("t3_b2b_ready", mem_ready, 1);
        tick();
        clear_ex();
        check("t3_b2b_valid", mem_valid, 1);
        check("t3_b2b_pc", pc_mem, 32'h204);
        check("t3_b2b_alu", alu_res_mem, 32'h5678);
        tick();
        wb_ready = 0;
        check("t3_idle", mem_valid, 0);

        // 4: request stalled for 4 cycles; stray response and new EX data must not disturb it.
        ex_valid = 1; mem_wen_ex = 1; mem_funct3_ex = 3'b010; alu_res_ex = 32'h8000_0010;
        store_data_ex = 32'hDEAD_BEEF;
        tick();
        clear_ex();
        ex_valid = 1; alu_res_ex = 32'h0000_0099; store_data_ex = 32'h1111_1111;
        dmem_resp_valid = 1;
        for (int i = 0; i < 4; i++) begin
            check("t4_req_valid", dmem_req_valid, 1);
            check("t4_addr", dmem_addr, 32'h8000_0010);
            check("t4_wdata", dmem_wdata, 32'hDEAD_BEEF);
            check("t4_wstrb", {28'd0, dmem_wstrb}, 32'hF);
            check("t4_stall", mem_ready, 0);
            tick();
        end
        clear_ex();
        dmem_resp_valid = 0; dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0; dmem_resp_valid = 1;
        tick();
        dmem_resp_valid = 0;
        check("t4_hold", mem_valid, 1);
        check("t4_alu_kept", alu_res_mem, 32'h8000_0010);
        wb_ready = 1;
        tick();
        wb_ready = 0;

        // Extension and lane vectors.
        do_load("lh",  3'b001, 32'h2, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h2, 32'h8001_1234, 32'h0000_8001);
        do_load("lbu", 3'b100, 32'h1, 32'h0000_F500, 32'h0000_00F5);
        do_load("lw",  3'b010, 32'h0, 32'h1234_5678, 32'h1234_5678);
        do_load("lb",  3'b000, 32'h0, 32'hFFFF_FF7F, 32'h0000_007F);
        do_store("sb", 3'b000, 32'h1, 32'h0000_00AB, 4'b0010, 32'h0000_AB00);
        do_store("sw", 3'b010, 32'h4, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // 5: reset while waiting in RESP; the late response must be dropped.
        ex_valid = 1; mem_ren_ex = 1; mem_funct3_ex = 3'b010; alu_res_ex = 32'h40; pc_ex = 32'h300;
        rf_wen_ex = 1;
        tick();
        clear_ex();
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        reset = 0;
        #1;
        check("t5_rst_req", dmem_req_valid, 0);
        check("t5_rst_valid", mem_valid, 0);
        check("t5_rst_pc", pc_mem, 0);
        check("t5_rst_rf_wen", rf_wen_mem, 0);
        dmem_resp_valid = 1; dmem_rdata = 32'h5555_5555;
        tick();
        reset = 1;
        tick();
        dmem_resp_valid = 0;
        check("t5_late_valid", mem_valid, 0);
        check("t5_late_ready", mem_ready, 1);
        check("t5_late_req", dmem_req_valid, 0);
        check("t5_late_data", load_data_mem, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        // 6: misaligned LW traps without a bus request.
        ex_valid = 1; mem_ren_ex = 1; mem_funct3_ex = 3'b010; alu_res_ex = 32'h8000_0001;
        rf_wen_ex = 1;
        tick();
        clear_ex();
        check("t6_no_req", dmem_req_valid, 0);
        check("t6_valid", mem_valid, 1);
        check("t6_misalign", misalign_mem, 1);
        check("t6_rf_wen", rf_wen_mem, 0);
        check("t6_data", load_data_mem, 0);
        wb_ready = 1;
        tick();
        wb_ready = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
